// File: rtl/multicycle_control_if.sv
// Memory-bus handshake between the multicycle control FSM and the shared
// single-port memory.
//   mem_valid : bus request from the controller
//   memwrite  : store strobe, qualifies mem_valid
//   mem_ready : completion from memory, valid in the cycle it is high
interface multicycle_control_if;
    logic mem_valid;
    logic memwrite;
    logic mem_ready;

    modport master (output mem_valid, output memwrite, input mem_ready);
    modport slave  (input mem_valid, input memwrite, output mem_ready);
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the rv32i multicycle core. Every instruction walks
// fetch -> decode -> execute/memory -> writeback; memory states hold until
// the bus handshake completes.
//   clk, reset   : core clock, synchronous active-high reset
//   i_opcode     : instr[6:0] from the IR
//   bus          : memory handshake (mem_valid, memwrite out; mem_ready in)
//   o_state      : current FSM state (debug)
//   o_immsrc     : immediate format select
//   o_alusrca/b  : ALU operand selects, o_aluop: ALU operation class
//   o_resultsrc  : result mux select, o_adrsrc: memory address select
//   o_irwrite, o_pcupdate, o_branch, o_regwrite : datapath strobes
//   o_illegal_instr : one-cycle pulse on an undecodable opcode
module multicycle_control #(
    parameter bit FENCE_IS_NOP = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [6:0]             i_opcode,
    multicycle_control_if.master   bus,
    output logic [3:0]             o_state,
    output logic [2:0]             o_immsrc,
    output logic [1:0]             o_alusrca,
    output logic [1:0]             o_alusrcb,
    output logic [1:0]             o_aluop,
    output logic [1:0]             o_resultsrc,
    output logic                   o_adrsrc,
    output logic                   o_irwrite,
    output logic                   o_pcupdate,
    output logic                   o_branch,
    output logic                   o_regwrite,
    output logic                   o_illegal_instr
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,  S_DECODE   = 4'd1,  S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,  S_MEMWB    = 4'd4,  S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,  S_EXECUTEI = 4'd7,  S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,  S_JAL      = 4'd10, S_JALR     = 4'd11,
        S_LUI      = 4'd12, S_AUIPC    = 4'd13
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_FENCE = 7'b0001111;

    localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2,
                           IMM_J = 3'd3, IMM_U = 3'd4;

    state_t r_state;
    state_t w_next;
    logic   w_mem_valid, w_memwrite;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next          = S_FETCH;
        o_immsrc        = IMM_I;
        o_alusrca       = 2'b00;
        o_alusrcb       = 2'b00;
        o_aluop         = 2'b00;
        o_resultsrc     = 2'b00;
        o_adrsrc        = 1'b0;
        w_mem_valid     = 1'b0;
        w_memwrite      = 1'b0;
        o_irwrite       = 1'b0;
        o_pcupdate      = 1'b0;
        o_branch        = 1'b0;
        o_regwrite      = 1'b0;
        o_illegal_instr = 1'b0;
        case (r_state)
            S_FETCH: begin
                // PC+4 is computed while the instruction word is fetched
                w_mem_valid = 1'b1;
                o_alusrcb   = 2'b10;
                o_resultsrc = 2'b10;
                o_irwrite   = bus.mem_ready;
                o_pcupdate  = bus.mem_ready;
                w_next      = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // speculative oldPC+imm target for branches and JAL
                o_alusrca = 2'b01;
                o_alusrcb = 2'b01;
                o_immsrc  = (i_opcode == OP_JAL) ? IMM_J : IMM_B;
                case (i_opcode)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_R:              w_next = S_EXECUTER;
                    OP_I:              w_next = S_EXECUTEI;
                    OP_BR:             w_next = S_BRANCH;
                    OP_JAL:            w_next = S_JAL;
                    OP_JALR:           w_next = S_JALR;
                    OP_LUI:            w_next = S_LUI;
                    OP_AUIPC:          w_next = S_AUIPC;
                    OP_FENCE:          o_illegal_instr = !FENCE_IS_NOP;
                    default:           o_illegal_instr = 1'b1;
                endcase
            end
            S_MEMADR: begin
                o_alusrca = 2'b10;
                o_alusrcb = 2'b01;
                o_immsrc  = (i_opcode == OP_STORE) ? IMM_S : IMM_I;
                w_next    = (i_opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_mem_valid = 1'b1;
                o_adrsrc    = 1'b1;
                w_next      = bus.mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                o_resultsrc = 2'b01;
                o_regwrite  = 1'b1;
            end
            S_MEMWRITE: begin
                w_mem_valid = 1'b1;
                w_memwrite  = 1'b1;
                o_adrsrc    = 1'b1;
                w_next      = bus.mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTER: begin
                o_alusrca = 2'b10;
                o_aluop   = 2'b10;
                w_next    = S_ALUWB;
            end
            S_EXECUTEI: begin
                o_alusrca = 2'b10;
                o_alusrcb = 2'b01;
                o_aluop   = 2'b10;
                w_next    = S_ALUWB;
            end
            S_ALUWB: o_regwrite = 1'b1;
            S_BRANCH: begin
                o_alusrca = 2'b10;
                o_aluop   = 2'b01;
                o_branch  = 1'b1;
            end
            S_JALR: begin
                // rs1+imm target; JAL then loads the PC and writes oldPC+4
                o_alusrca = 2'b10;
                o_alusrcb = 2'b01;
                w_next    = S_JAL;
            end
            S_JAL: begin
                o_alusrca  = 2'b01;
                o_alusrcb  = 2'b10;
                o_pcupdate = 1'b1;
                w_next     = S_ALUWB;
            end
            S_LUI: begin
                o_alusrca = 2'b11;
                o_alusrcb = 2'b01;
                o_immsrc  = IMM_U;
                w_next    = S_ALUWB;
            end
            S_AUIPC: begin
                o_alusrca = 2'b01;
                o_alusrcb = 2'b01;
                o_immsrc  = IMM_U;
                w_next    = S_ALUWB;
            end
            default: w_next = S_FETCH;
        endcase
        // reset abandons any access in flight
        if (reset) begin
            w_mem_valid     = 1'b0;
            w_memwrite      = 1'b0;
            o_irwrite       = 1'b0;
            o_pcupdate      = 1'b0;
            o_branch        = 1'b0;
            o_regwrite      = 1'b0;
            o_illegal_instr = 1'b0;
        end
    end

    assign bus.mem_valid = w_mem_valid;
    assign bus.memwrite  = w_memwrite;
    assign o_state       = r_state;
endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;
    localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RR = 7'b0110011,
                           II = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111,
                           JR = 7'b1100111, LU = 7'b0110111, AU = 7'b0010111,
                           FN = 7'b0001111, BAD = 7'b1111111;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [6:0] opcode = 7'd0;
    always #5 clk = ~clk;

    multicycle_control_if bus1();
    multicycle_control_if bus2();

    logic [3:0] st1, st2;
    logic [2:0] imm1, imm2;
    logic [1:0] a1, a2, b1, b2, op1, op2, res1, res2;
    logic adr1, adr2, ir1, ir2, pc1, pc2, br1, br2, rw1, rw2, il1, il2;

    multicycle_control #(.FENCE_IS_NOP(1'b1)) dut1 (
        .clk(clk), .reset(reset), .i_opcode(opcode), .bus(bus1),
        .o_state(st1), .o_immsrc(imm1), .o_alusrca(a1), .o_alusrcb(b1),
        .o_aluop(op1), .o_resultsrc(res1), .o_adrsrc(adr1), .o_irwrite(ir1),
        .o_pcupdate(pc1), .o_branch(br1), .o_regwrite(rw1), .o_illegal_instr(il1));

    multicycle_control #(.FENCE_IS_NOP(1'b0)) dut2 (
        .clk(clk), .reset(reset), .i_opcode(opcode), .bus(bus2),
        .o_state(st2), .o_immsrc(imm2), .o_alusrca(a2), .o_alusrcb(b2),
        .o_aluop(op2), .o_resultsrc(res2), .o_adrsrc(adr2), .o_irwrite(ir2),
        .o_pcupdate(pc2), .o_branch(br2), .o_regwrite(rw2), .o_illegal_instr(il2));

    // {state, mem_valid,memwrite,irwrite,pcupdate,branch,regwrite,illegal,
    //  immsrc, alusrca, alusrcb, aluop, resultsrc, adrsrc}
    logic [22:0] obs1, obs2;
    assign obs1 = {st1, bus1.mem_valid, bus1.memwrite, ir1, pc1, br1, rw1, il1,
                   imm1, a1, b1, op1, res1, adr1};
    assign obs2 = {st2, bus2.mem_valid, bus2.memwrite, ir2, pc2, br2, rw2, il2,
                   imm2, a2, b2, op2, res2, adr2};

    typedef struct packed {logic rst; logic rdy; logic [6:0] op;} stim_t;
    stim_t       stim_q[$];
    logic [22:0] exp_q[$];
    logic [22:0] exp2_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [22:0] ev(input logic [3:0] st, input logic [6:0] sb,
        input logic [2:0] imm, input logic [1:0] sa, input logic [1:0] sbb,
        input logic [1:0] op, input logic [1:0] res, input logic adr);
        return {st, sb, imm, sa, sbb, op, res, adr};
    endfunction

    // common expected vectors
    function automatic logic [22:0] f0();  return ev(4'd0, 7'b1000000, 3'd0, 2'd0, 2'd2, 2'd0, 2'd2, 1'b0); endfunction
    function automatic logic [22:0] f1();  return ev(4'd0, 7'b1011000, 3'd0, 2'd0, 2'd2, 2'd0, 2'd2, 1'b0); endfunction
    function automatic logic [22:0] dec(input logic [2:0] imm, input logic il);
        return ev(4'd1, {6'b0, il}, imm, 2'd1, 2'd1, 2'd0, 2'd0, 1'b0);
    endfunction
    function automatic logic [22:0] aluwb(); return ev(4'd8, 7'b0000010, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0); endfunction

    task automatic push(input logic r, input logic rdy, input logic [6:0] op, input logic [22:0] e);
        stim_q.push_back('{rst: r, rdy: rdy, op: op});
        exp_q.push_back(e);
        exp2_q.push_back(e);
    endtask

    task automatic drive(input stim_t s);
        reset = s.rst;
        opcode = s.op;
        bus1.mem_ready = s.rdy;
        bus2.mem_ready = s.rdy;
    endtask

    task automatic test_reset();
        stim_t s; logic [22:0] e; logic [22:0] e2; int k = 0;
        bus1.mem_ready = 1'b1; bus2.mem_ready = 1'b1;
        @(posedge clk); #1;
        push(1, 1, 0, ev(4'd0, 7'b0, 3'd0, 2'd0, 2'd2, 2'd0, 2'd2, 1'b0));
        push(1, 1, 0, ev(4'd0, 7'b0, 3'd0, 2'd0, 2'd2, 2'd0, 2'd2, 1'b0));
        push(0, 0, RR, f0());
        push(0, 0, RR, f0());
        push(0, 1, RR, f1());
        push(0, 1, RR, dec(3'd2, 1'b0));
        push(0, 1, RR, ev(4'd6, 7'b0, 3'd0, 2'd2, 2'd0, 2'd2, 2'd0, 1'b0));
        push(0, 1, RR, aluwb());
        push(0, 0, RR, f0());
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); drive(s);
            @(negedge clk);
            e = exp_q.pop_front(); e2 = exp2_q.pop_front(); k++;
            n_checks++;
            if (obs1 !== e) begin
                n_fail++;
                $display("FAIL reset step %0d: observed %h required %h", k, obs1, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load();
        stim_t s; logic [22:0] e; logic [22:0] e2; int k = 0;
        push(0, 1, LD, f1());
        push(0, 0, LD, dec(3'd2, 1'b0));
        push(0, 1, LD, ev(4'd2, 7'b0, 3'd0, 2'd2, 2'd1, 2'd0, 2'd0, 1'b0));
        push(0, 0, LD, ev(4'd3, 7'b1000000, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1));
        push(0, 1, LD, ev(4'd3, 7'b1000000, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1));
        push(0, 0, LD, ev(4'd4, 7'b0000010, 3'd0, 2'd0, 2'd0, 2'd0, 2'd1, 1'b0));
        push(0, 0, LD, f0());
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); drive(s);
            @(negedge clk);
            e = exp_q.pop_front(); e2 = exp2_q.pop_front(); k++;
            n_checks++;
            if (obs1 !== e) begin
                n_fail++;
                $display("FAIL load step %0d: observed %h required %h", k, obs1, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_store();
        stim_t s; logic [22:0] e; logic [22:0] e2; int k = 0;
        push(0, 1, ST, f1());
        push(0, 0, ST, dec(3'd2, 1'b0));
        push(0, 0, ST, ev(4'd2, 7'b0, 3'd1, 2'd2, 2'd1, 2'd0, 2'd0, 1'b0));
        for (int i = 0; i < 3; i++)
            push(0, 0, ST, ev(4'd5, 7'b1100000, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1));
        push(0, 1, ST, ev(4'd5, 7'b1100000, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1));
        push(0, 0, ST, f0());
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); drive(s);
            @(negedge clk);
            e = exp_q.pop_front(); e2 = exp2_q.pop_front(); k++;
            n_checks++;
            if (obs1 !== e) begin
                n_fail++;
                $display("FAIL store step %0d: observed %h required %h", k, obs1, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_jumps();
        stim_t s; logic [22:0] e; logic [22:0] e2; int k = 0;
        push(0, 1, JR, f1());
        push(0, 0, JR, dec(3'd2, 1'b0));
        push(0, 1, JR, ev(4'd11, 7'b0, 3'd0, 2'd2, 2'd1, 2'd0, 2'd0, 1'b0));
        push(0, 0, JR, ev(4'd10, 7'b0001000, 3'd0, 2'd1, 2'd2, 2'd0, 2'd0, 1'b0));
        push(0, 1, JR, aluwb());
        push(0, 0, JR, f0());
        push(0, 1, JL, f1());
        push(0, 0, JL, dec(3'd3, 1'b0));
        push(0, 0, JL, ev(4'd10, 7'b0001000, 3'd0, 2'd1, 2'd2, 2'd0, 2'd0, 1'b0));
        push(0, 0, JL, aluwb());
        push(0, 0, JL, f0());
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); drive(s);
            @(negedge clk);
            e = exp_q.pop_front(); e2 = exp2_q.pop_front(); k++;
            n_checks++;
            if (obs1 !== e) begin
                n_fail++;
                $display("FAIL jumps step %0d: observed %h required %h", k, obs1, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_alu_branch();
        stim_t s; logic [22:0] e; logic [22:0] e2; int k = 0;
        push(0, 1, BR, f1());
        push(0, 0, BR, dec(3'd2, 1'b0));
        push(0, 1, BR, ev(4'd9, 7'b0000100, 3'd0, 2'd2, 2'd0, 2'd1, 2'd0, 1'b0));
        push(0, 0, BR, f0());
        push(0, 1, II, f1());
        push(0, 0, II, dec(3'd2, 1'b0));
        push(0, 0, II, ev(4'd7, 7'b0, 3'd0, 2'd2, 2'd1, 2'd2, 2'd0, 1'b0));
        push(0, 0, II, aluwb());
        push(0, 0, II, f0());
        push(0, 1, LU, f1());
        push(0, 0, LU, dec(3'd2, 1'b0));
        push(0, 0, LU, ev(4'd12, 7'b0, 3'd4, 2'd3, 2'd1, 2'd0, 2'd0, 1'b0));
        push(0, 0, LU, aluwb());
        push(0, 0, LU, f0());
        push(0, 1, AU, f1());
        push(0, 0, AU, dec(3'd2, 1'b0));
        push(0, 0, AU, ev(4'd13, 7'b0, 3'd4, 2'd1, 2'd1, 2'd0, 2'd0, 1'b0));
        push(0, 0, AU, aluwb());
        push(0, 0, AU, f0());
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); drive(s);
            @(negedge clk);
            e = exp_q.pop_front(); e2 = exp2_q.pop_front(); k++;
            n_checks++;
            if (obs1 !== e) begin
                n_fail++;
                $display("FAIL alu_branch step %0d: observed %h required %h", k, obs1, e);
            end
            @(posedge clk); #1;
        end
    endtask

    // both instances see the same stimulus; only FENCE decoding differs
    task automatic test_illegal_fence();
        stim_t s; logic [22:0] e; logic [22:0] e2; int k = 0;
        push(0, 1, BAD, f1());
        push(0, 0, BAD, dec(3'd2, 1'b1));
        push(0, 0, BAD, f0());
        push(0, 1, FN, f1());
        push(0, 0, FN, dec(3'd2, 1'b0));
        exp2_q[exp2_q.size()-1] = dec(3'd2, 1'b1);
        push(0, 0, FN, f0());
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); drive(s);
            @(negedge clk);
            e = exp_q.pop_front(); e2 = exp2_q.pop_front(); k++;
            n_checks += 2;
            if (obs1 !== e) begin
                n_fail++;
                $display("FAIL illegal_nop step %0d: observed %h required %h", k, obs1, e);
            end
            if (obs2 !== e2) begin
                n_fail++;
                $display("FAIL illegal_strict step %0d: observed %h required %h", k, obs2, e2);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_access();
        stim_t s; logic [22:0] e; logic [22:0] e2; int k = 0;
        push(0, 1, LD, f1());
        push(0, 0, LD, dec(3'd2, 1'b0));
        push(0, 0, LD, ev(4'd2, 7'b0, 3'd0, 2'd2, 2'd1, 2'd0, 2'd0, 1'b0));
        push(1, 1, LD, ev(4'd3, 7'b0, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1));
        push(1, 1, LD, ev(4'd0, 7'b0, 3'd0, 2'd0, 2'd2, 2'd0, 2'd2, 1'b0));
        push(0, 0, LD, f0());
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); drive(s);
            @(negedge clk);
            e = exp_q.pop_front(); e2 = exp2_q.pop_front(); k++;
            n_checks++;
            if (obs1 !== e) begin
                n_fail++;
                $display("FAIL reset_mid step %0d: observed %h required %h", k, obs1, e);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        bus1.mem_ready = 1'b0;
        bus2.mem_ready = 1'b0;
        test_reset();
        test_load();
        test_store();
        test_jumps();
        test_alu_branch();
        test_illegal_fence();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
